// File: rtl/gate_checker_pkg.sv
// Shared types and constants for the gate_checker truth-table sweeper.
// The optional FAIL_MASK feature is enabled by defining GATE_CHECKER_FAILMASK_EN.
package gate_checker_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam int         NUM_VECTORS = 4;
    localparam logic [3:0] NAND_TRUTH  = 4'b0111;
    localparam logic [2:0] ERR_MAX     = 3'd4;

    // Mismatch counter increment that never wraps past the number of vectors.
    function automatic logic [2:0] sat_inc(input logic [2:0] value);
        return (value >= ERR_MAX) ? ERR_MAX : value + 3'd1;
    endfunction

endpackage

// File: rtl/gate_checker_settle_counter.sv
// Loadable down-counter timing the SETTLE phase; tc is high once the count reaches zero.
module settle_counter
    import gate_checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       tc
);

    logic [3:0] cnt_r;

    // Count register: load wins over decrement, and the count parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == 4'd0);

endmodule

// File: rtl/gate_checker.sv
// Sweeps {A,B} over 00..11, compares Y against TRUTH and reports the mismatch count.
// Define GATE_CHECKER_FAILMASK_EN to add the per-vector FAIL_MASK output.
module gate_checker
    import gate_checker_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] TRUTH         = NAND_TRUTH
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] ERR_CNT
`ifdef GATE_CHECKER_FAILMASK_EN
    ,
    output logic [3:0] FAIL_MASK
`endif
);

    localparam bit         SKIP_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [3:0] SETTLE_LOAD = SKIP_SETTLE ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);

    state_t     state_r;
    state_t     state_s;
    logic [1:0] idx_r;
    logic       a_r;
    logic       b_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [2:0] err_cnt_r;
    logic       load_s;
    logic       en_s;
    logic       tc_s;
    logic       mismatch_s;

    assign load_s     = (state_r == DRIVE);
    assign en_s       = (state_r == SETTLE);
    assign mismatch_s = (Y != TRUTH[idx_r]);

    settle_counter u_settle (
        .clk      (CLK),
        .rst      (RST),
        .load     (load_s),
        .load_val (SETTLE_LOAD),
        .en       (en_s),
        .tc       (tc_s)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; START is only looked at in IDLE, so FIN ignores it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (START) state_s = DRIVE;
                else       state_s = IDLE;
            end
            DRIVE: begin
                if (SKIP_SETTLE) state_s = SAMPLE;
                else             state_s = SETTLE;
            end
            SETTLE: begin
                if (tc_s) state_s = SAMPLE;
                else      state_s = SETTLE;
            end
            SAMPLE: begin
                if (idx_r == LAST_IDX) state_s = FIN;
                else                   state_s = DRIVE;
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath: stimulus, status flags and mismatch bookkeeping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_r     <= 2'd0;
            a_r       <= 1'b0;
            b_r       <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_cnt_r <= 3'd0;
        end else begin
            busy_r <= (state_s != IDLE);
            // DONE follows FIN by one register stage, so PASS and DONE rise together.
            done_r <= (state_r == FIN);
            case (state_r)
                IDLE: begin
                    if (START) begin
                        idx_r     <= 2'd0;
                        a_r       <= 1'b0;
                        b_r       <= 1'b0;
                        pass_r    <= 1'b0;
                        err_cnt_r <= 3'd0;
                    end
                end
                SAMPLE: begin
                    if (mismatch_s) err_cnt_r <= sat_inc(err_cnt_r);
                    if (idx_r != LAST_IDX) begin
                        idx_r      <= idx_r + 2'd1;
                        {a_r, b_r} <= idx_r + 2'd1;
                    end
                end
                FIN:     pass_r <= (err_cnt_r == 3'd0);
                default: pass_r <= pass_r;
            endcase
        end
    end

`ifdef GATE_CHECKER_FAILMASK_EN
    logic [3:0] fail_mask_r;

    // Per-vector mismatch flags, cleared by an accepted START.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fail_mask_r <= 4'd0;
        end else if ((state_r == IDLE) && START) begin
            fail_mask_r <= 4'd0;
        end else if ((state_r == SAMPLE) && mismatch_s) begin
            fail_mask_r[idx_r] <= 1'b1;
        end else begin
            fail_mask_r <= fail_mask_r;
        end
    end

    assign FAIL_MASK = fail_mask_r;
`endif

    assign A       = a_r;
    assign B       = b_r;
    assign BUSY    = busy_r;
    assign DONE    = done_r;
    assign PASS    = pass_r;
    assign ERR_CNT = err_cnt_r;

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench: dut 0 uses SETTLE_CYCLES=2, dut 1 uses SETTLE_CYCLES=0.
module tb_gate_checker;

    typedef struct {
        int         lat;
        logic [2:0] err;
        logic       pass;
        logic [3:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       y     [2];
    logic       a     [2];
    logic       b     [2];
    logic       busy  [2];
    logic       done  [2];
    logic       pass_o[2];
    logic [2:0] err   [2];
    int         model [2];
`ifdef GATE_CHECKER_FAILMASK_EN
    logic [3:0] mask  [2];
`endif

    always #5 clk = ~clk;

    // 0: NAND, 1: stuck at 1, 2: AND
    function automatic logic model_y(input int mdl, input logic ai, input logic bi);
        case (mdl)
            0:       return ~(ai & bi);
            1:       return 1'b1;
            default: return ai & bi;
        endcase
    endfunction

    assign y[0] = model_y(model[0], a[0], b[0]);
    assign y[1] = model_y(model[1], a[1], b[1]);

    gate_checker #(.SETTLE_CYCLES(2)) dut0 (
        .CLK(clk), .RST(rst), .START(start[0]), .Y(y[0]),
        .A(a[0]), .B(b[0]), .BUSY(busy[0]), .DONE(done[0]),
        .PASS(pass_o[0]), .ERR_CNT(err[0])
`ifdef GATE_CHECKER_FAILMASK_EN
        , .FAIL_MASK(mask[0])
`endif
    );

    gate_checker #(.SETTLE_CYCLES(0)) dut1 (
        .CLK(clk), .RST(rst), .START(start[1]), .Y(y[1]),
        .A(a[1]), .B(b[1]), .BUSY(busy[1]), .DONE(done[1]),
        .PASS(pass_o[1]), .ERR_CNT(err[1])
`ifdef GATE_CHECKER_FAILMASK_EN
        , .FAIL_MASK(mask[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t predict(input int mdl, input int n);
        exp_t       e;
        logic [3:0] tt;
        logic [1:0] v;
        tt     = 4'b0111;
        e.lat  = 4 * (n + 2) + 1;
        e.err  = 3'd0;
        e.mask = 4'd0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            if (model_y(mdl, v[1], v[0]) != tt[i]) begin
                e.err     = e.err + 3'd1;
                e.mask[i] = 1'b1;
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    task automatic check_cleared(input int d);
        check_eq("rst_busy", busy[d], 0);
        check_eq("rst_done", done[d], 0);
        check_eq("rst_pass", pass_o[d], 0);
        check_eq("rst_err", err[d], 0);
        check_eq("rst_ab", {a[d], b[d]}, 0);
`ifdef GATE_CHECKER_FAILMASK_EN
        check_eq("rst_mask", mask[d], 0);
`endif
    endtask

    // fresh=0 continues a sweep already requested by a held START.
    task automatic run(input int d, input int mdl, input bit fresh, input bit hold, input int abort_k);
        exp_t e;
        int   k;
        int   n;
        bit   seen;
        n = (d == 0) ? 2 : 0;
        if (fresh) begin
            @(negedge clk);
            model[d] = mdl;
            start[d] = 1'b1;
        end
        sb_q.push_back(predict(mdl, n));
        @(posedge clk);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(negedge clk);
            if (!hold) start[d] = 1'b0;
            if (k == 0) begin
                check_eq("busy_start", busy[d], 1);
                check_eq("done_pulse", done[d], 0);
            end
            if (k < 4 * (n + 2) && (k % (n + 2)) == 0)
                check_eq("ab_seq", {a[d], b[d]}, k / (n + 2));
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                check_cleared(d);
                e = sb_q.pop_front();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done[d]) begin
                seen = 1'b1;
                e    = sb_q.pop_front();
                check_eq("latency", k, e.lat);
                check_eq("err_cnt", err[d], e.err);
                check_eq("pass", pass_o[d], e.pass);
                check_eq("ab_hold", {a[d], b[d]}, 3);
                check_eq("busy_end", busy[d], 0);
`ifdef GATE_CHECKER_FAILMASK_EN
                check_eq("fail_mask", mask[d], e.mask);
`endif
            end else begin
                @(posedge clk);
                k++;
            end
        end
        if (!seen) check_eq("done_timeout", 0, 1);
    endtask

    initial begin
        rst      = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        model[0] = 0;
        model[1] = 0;
        repeat (3) @(negedge clk);
        check_cleared(0);
        check_cleared(1);
        rst = 1'b0;

        run(0, 0, 1'b1, 1'b0, -1);
        run(0, 1, 1'b1, 1'b0, -1);
        run(0, 2, 1'b1, 1'b0, -1);
        repeat (3) @(negedge clk);
        check_eq("err_hold", err[0], 4);
        run(0, 0, 1'b1, 1'b1, -1);
        run(0, 0, 1'b0, 1'b0, -1);
        run(0, 0, 1'b1, 1'b0, 9);
        run(0, 0, 1'b1, 1'b0, -1);
        run(1, 0, 1'b1, 1'b0, -1);
        run(1, 2, 1'b1, 1'b0, -1);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
